// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: opcodes, mux encodings,
// FSM state enum and the control-strobe bundle driven to the datapath.
package mips_pkg;

    localparam int unsigned OPC_W = 6;

    localparam logic [OPC_W-1:0] OPC_RTYPE = 6'b000000;
    localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
    localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
    localparam logic [OPC_W-1:0] OPC_BEQ   = 6'b000100;
    localparam logic [OPC_W-1:0] OPC_ADDI  = 6'b001000;
    localparam logic [OPC_W-1:0] OPC_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic CAUSE_ILLEGAL = 1'b0;
    localparam logic CAUSE_TIMEOUT = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12,
        ST_TRAP   = 4'd13
    } state_e;

    typedef struct packed {
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
        logic       instr_done;
        logic       trap;
        logic       trap_cause;
    } ctrl_t;

    // States that stall on the memory handshake and run the wait counter.
    function automatic logic is_wait_state(input state_e st);
        return (st == ST_FETCH) || (st == ST_MEMRD) || (st == ST_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore-style sequencer for the shared multi-cycle MIPS datapath, with a memory
// wait counter that traps on handshake timeout and on unknown opcodes.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned TMR_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdst,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsrc,
    output logic       instr_done,
    output logic       trap,
    output logic       trap_cause,
    output logic [3:0] state
);

    localparam logic             TMO_EN   = (MEM_TIMEOUT != 0);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] cnt_q, cnt_d;
    logic             cause_q, cause_d;
    logic             timeout_c;
    ctrl_t            ctrl_c;

    // A ready handshake in the same cycle always beats the timeout.
    assign timeout_c = TMO_EN && !mem_ready && (cnt_q == TMR_LAST);

    // Next-state, trap cause and wait-counter update.
    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OPC_RTYPE:      state_d = ST_EXEC;
                    OPC_LW, OPC_SW: state_d = ST_MEMADR;
                    OPC_BEQ:        state_d = ST_BRANCH;
                    OPC_ADDI:       state_d = ST_ADDIEX;
                    OPC_J:          state_d = ST_JUMP;
                    default: begin
                        state_d = ST_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            ST_MEMADR: state_d = (opcode == OPC_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD: begin
                if (mem_ready) begin
                    state_d = ST_MEMWB;
                end else if (timeout_c) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_MEMWR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (timeout_c) begin
                    state_d = ST_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            ST_EXEC:   state_d = ST_ALUWB;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP, ST_TRAP:
                state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase

        // Counter restarts on every entry to a wait state and saturates otherwise.
        if (is_wait_state(state_q) && (state_d == state_q) && !mem_ready) begin
            cnt_d = (cnt_q == TMR_MAX) ? cnt_q : cnt_q + TMR_W'(1);
        end
    end

    // Per-state control decode; FETCH additionally qualifies IR/PC writes with mem_ready.
    always_comb begin
        ctrl_c = '0;
        case (state_q)
            ST_FETCH: begin
                ctrl_c.memread = 1'b1;
                ctrl_c.alusrcb = SRCB_FOUR;
                ctrl_c.aluop   = ALUOP_ADD;
                ctrl_c.pcsrc   = PCSRC_ALU;
                ctrl_c.irwrite = mem_ready;
                ctrl_c.pcwrite = mem_ready;
            end
            ST_DECODE: begin
                ctrl_c.alusrcb = SRCB_IMM_SH2;
                ctrl_c.aluop   = ALUOP_ADD;
            end
            ST_MEMADR: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_IMM;
                ctrl_c.aluop   = ALUOP_ADD;
            end
            ST_MEMRD: begin
                ctrl_c.memread = 1'b1;
                ctrl_c.iord    = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_c.memtoreg   = 1'b1;
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_MEMWR: begin
                ctrl_c.memwrite   = 1'b1;
                ctrl_c.iord       = 1'b1;
                ctrl_c.instr_done = mem_ready;
            end
            ST_EXEC: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_B;
                ctrl_c.aluop   = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl_c.regdst     = 1'b1;
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_c.alusrca     = 1'b1;
                ctrl_c.alusrcb     = SRCB_B;
                ctrl_c.aluop       = ALUOP_SUB;
                ctrl_c.pcwritecond = 1'b1;
                ctrl_c.pcsrc       = PCSRC_ALUOUT;
                ctrl_c.instr_done  = 1'b1;
            end
            ST_ADDIEX: begin
                ctrl_c.alusrca = 1'b1;
                ctrl_c.alusrcb = SRCB_IMM;
                ctrl_c.aluop   = ALUOP_ADD;
            end
            ST_ADDIWB: begin
                ctrl_c.regwrite   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            ST_JUMP: begin
                ctrl_c.pcwrite    = 1'b1;
                ctrl_c.pcsrc      = PCSRC_JUMP;
                ctrl_c.instr_done = 1'b1;
            end
            ST_TRAP: begin
                ctrl_c.trap       = 1'b1;
                ctrl_c.trap_cause = cause_q;
            end
            default: ctrl_c = '0;
        endcase
    end

    // State, wait counter and latched trap cause; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cause_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign pcwrite     = ctrl_c.pcwrite;
    assign pcwritecond = ctrl_c.pcwritecond;
    assign iord        = ctrl_c.iord;
    assign memread     = ctrl_c.memread;
    assign memwrite    = ctrl_c.memwrite;
    assign irwrite     = ctrl_c.irwrite;
    assign memtoreg    = ctrl_c.memtoreg;
    assign regdst      = ctrl_c.regdst;
    assign regwrite    = ctrl_c.regwrite;
    assign alusrca     = ctrl_c.alusrca;
    assign alusrcb     = ctrl_c.alusrcb;
    assign aluop       = ctrl_c.aluop;
    assign pcsrc       = ctrl_c.pcsrc;
    assign instr_done  = ctrl_c.instr_done;
    assign trap        = ctrl_c.trap;
    assign trap_cause  = ctrl_c.trap_cause;
    assign state       = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: each driven cycle queues its
// hand-computed state/strobe vector, and a negedge monitor pops and compares.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca;
    logic [1:0] alusrcb, aluop, pcsrc;
    logic       instr_done, trap, trap_cause;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4), .TMR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
        .memwrite(memwrite), .irwrite(irwrite), .memtoreg(memtoreg), .regdst(regdst),
        .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
        .pcsrc(pcsrc), .instr_done(instr_done), .trap(trap), .trap_cause(trap_cause),
        .state(state)
    );

    localparam logic [3:0] S_IDLE = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2, S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD = 4'd4, S_MEMWB = 4'd5,  S_MEMWR = 4'd6,  S_EXEC = 4'd7;
    localparam logic [3:0] S_ALUWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11;
    localparam logic [3:0] S_JUMP = 4'd12, S_TRAP = 4'd13;

    localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    // {pw,pwc,iord,mrd,mwr,irw}_{mtr,rdst,rwr,asa}_srcb_aluop_pcsrc_{done,trap,cause}
    localparam logic [18:0] C_IDLE   = 19'b000000_0000_00_00_00_000;
    localparam logic [18:0] C_FRDY   = 19'b100101_0000_01_00_00_000;
    localparam logic [18:0] C_FWAIT  = 19'b000100_0000_01_00_00_000;
    localparam logic [18:0] C_DEC    = 19'b000000_0000_11_00_00_000;
    localparam logic [18:0] C_MEMADR = 19'b000000_0001_10_00_00_000;
    localparam logic [18:0] C_MEMRD  = 19'b001100_0000_00_00_00_000;
    localparam logic [18:0] C_MEMWB  = 19'b000000_1010_00_00_00_100;
    localparam logic [18:0] C_WRWAIT = 19'b001010_0000_00_00_00_000;
    localparam logic [18:0] C_WRRDY  = 19'b001010_0000_00_00_00_100;
    localparam logic [18:0] C_EXEC   = 19'b000000_0001_00_10_00_000;
    localparam logic [18:0] C_ALUWB  = 19'b000000_0110_00_00_00_100;
    localparam logic [18:0] C_BRANCH = 19'b010000_0001_00_01_01_100;
    localparam logic [18:0] C_ADDIEX = 19'b000000_0001_10_00_00_000;
    localparam logic [18:0] C_ADDIWB = 19'b000000_0010_00_00_00_100;
    localparam logic [18:0] C_JUMP   = 19'b100000_0000_00_00_10_100;
    localparam logic [18:0] C_TRAP0  = 19'b000000_0000_00_00_00_010;
    localparam logic [18:0] C_TRAP1  = 19'b000000_0000_00_00_00_011;

    typedef struct {
        logic [3:0]  st;
        logic [18:0] ctrl;
        string       nm;
    } exp_t;

    exp_t exp_q[$];

    logic [18:0] act_ctrl;
    assign act_ctrl = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                       memtoreg, regdst, regwrite, alusrca, alusrcb, aluop, pcsrc,
                       instr_done, trap, trap_cause};

    task automatic check(input string nm, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                     nm, act[22:19], act[18:0], exp[22:19], exp[18:0]);
        end
    endtask

    // Drive one cycle's inputs just after the edge and queue that cycle's expectation.
    task automatic step(input logic [5:0] opc, input logic rdy, input logic [3:0] st,
                        input logic [18:0] c, input string nm);
        @(posedge clk);
        #1;
        opcode    = opc;
        mem_ready = rdy;
        exp_q.push_back('{st, c, nm});
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.nm, {state, act_ctrl}, {e.st, e.ctrl});
        end
    end

    initial begin
        rst_n     = 1'b0;
        opcode    = R;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{S_IDLE, C_IDLE, "reset_held"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('{S_IDLE, C_IDLE, "reset_release"});

        // R-type, zero-wait memory: 4 cycles from FETCH
        step(R, 1'b1, S_FETCH,  C_FRDY,  "r_fetch");
        step(R, 1'b1, S_DECODE, C_DEC,   "r_decode");
        step(R, 1'b1, S_EXEC,   C_EXEC,  "r_exec");
        step(R, 1'b1, S_ALUWB,  C_ALUWB, "r_aluwb");

        // lw with three wait cycles in MEMRD; ready arrives on the last counter value
        step(LW, 1'b1, S_FETCH,  C_FRDY,   "lw_fetch");
        step(LW, 1'b1, S_DECODE, C_DEC,    "lw_decode");
        step(LW, 1'b1, S_MEMADR, C_MEMADR, "lw_memadr");
        for (int i = 0; i < 3; i++) step(LW, 1'b0, S_MEMRD, C_MEMRD, "lw_memrd_wait");
        step(LW, 1'b1, S_MEMRD,  C_MEMRD,  "lw_memrd_rdy");
        step(LW, 1'b1, S_MEMWB,  C_MEMWB,  "lw_memwb");

        // beq then j back to back
        step(BEQ, 1'b1, S_FETCH,  C_FRDY,   "beq_fetch");
        step(BEQ, 1'b1, S_DECODE, C_DEC,    "beq_decode");
        step(BEQ, 1'b1, S_BRANCH, C_BRANCH, "beq_branch");
        step(J,   1'b1, S_FETCH,  C_FRDY,   "j_fetch");
        step(J,   1'b1, S_DECODE, C_DEC,    "j_decode");
        step(J,   1'b1, S_JUMP,   C_JUMP,   "j_jump");

        // sw and addi with zero-wait memory
        step(SW,   1'b1, S_FETCH,  C_FRDY,   "sw_fetch");
        step(SW,   1'b1, S_DECODE, C_DEC,    "sw_decode");
        step(SW,   1'b1, S_MEMADR, C_MEMADR, "sw_memadr");
        step(SW,   1'b1, S_MEMWR,  C_WRRDY,  "sw_memwr_rdy");
        step(ADDI, 1'b1, S_FETCH,  C_FRDY,   "addi_fetch");
        step(ADDI, 1'b1, S_DECODE, C_DEC,    "addi_decode");
        step(ADDI, 1'b1, S_ADDIEX, C_ADDIEX, "addi_ex");
        step(ADDI, 1'b1, S_ADDIWB, C_ADDIWB, "addi_wb");

        // illegal opcode traps with cause 0
        step(BAD, 1'b1, S_FETCH,  C_FRDY,  "bad_fetch");
        step(BAD, 1'b1, S_DECODE, C_DEC,   "bad_decode");
        step(BAD, 1'b1, S_TRAP,   C_TRAP0, "bad_trap");

        // fetch timeout after 4 stalled cycles, then a retry that just makes it
        for (int i = 0; i < 4; i++) step(J, 1'b0, S_FETCH, C_FWAIT, "fetch_tmo_wait");
        step(J, 1'b1, S_TRAP, C_TRAP1, "fetch_tmo_trap");
        for (int i = 0; i < 3; i++) step(J, 1'b0, S_FETCH, C_FWAIT, "fetch_retry_wait");
        step(J, 1'b1, S_FETCH,  C_FRDY, "fetch_retry_rdy");
        step(J, 1'b1, S_DECODE, C_DEC,  "retry_decode");
        step(J, 1'b1, S_JUMP,   C_JUMP, "retry_jump");

        // store timeout in MEMWR
        step(SW, 1'b1, S_FETCH,  C_FRDY,   "swt_fetch");
        step(SW, 1'b1, S_DECODE, C_DEC,    "swt_decode");
        step(SW, 1'b1, S_MEMADR, C_MEMADR, "swt_memadr");
        for (int i = 0; i < 4; i++) step(SW, 1'b0, S_MEMWR, C_WRWAIT, "swt_memwr_wait");
        step(SW, 1'b1, S_TRAP, C_TRAP1, "swt_trap");

        // reset asserted mid-store must drop memwrite immediately
        step(SW, 1'b1, S_FETCH,  C_FRDY,   "swr_fetch");
        step(SW, 1'b1, S_DECODE, C_DEC,    "swr_decode");
        step(SW, 1'b1, S_MEMADR, C_MEMADR, "swr_memadr");
        step(SW, 1'b0, S_MEMWR,  C_WRWAIT, "swr_memwr_wait");
        #6;
        rst_n = 1'b0;
        #1;
        check("async_reset", {state, act_ctrl}, {S_IDLE, C_IDLE});
        @(posedge clk);
        #1;
        exp_q.push_back('{S_IDLE, C_IDLE, "swr_in_reset"});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.push_back('{S_IDLE, C_IDLE, "swr_release"});
        step(R, 1'b1, S_FETCH,  C_FRDY, "post_reset_fetch");
        step(R, 1'b1, S_DECODE, C_DEC,  "post_reset_decode");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style FSM that sequences the shared multi-cycle MIPS datapath: one memory, one ALU, IR/MDR/A/B/ALUOut holding registers.
- Decodes the 6-bit opcode latched in IR and drives per-state control strobes.
- Waits on a memory ready handshake and traps on illegal opcodes or memory timeouts.
- Sits between the IR opcode field and the datapath muxes/enables; ALU function decode stays in the existing aluop-driven ALU control.

Parameters:
- MEM_TIMEOUT, 15, max cycles to wait for mem_ready in a wait state; 0 disables the timeout.
- TMR_W, 8, width of the wait counter; MEM_TIMEOUT must be < 2**TMR_W.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- pcwrite, pcwritecond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca  out  1 each  datapath strobes/mux selects
- alusrcb  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- aluop  out  2  00=add, 01=sub, 10=funct
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  pulse on the final cycle of a retiring instruction
- trap  out  1  pulse, one cycle
- trap_cause  out  1  0=illegal opcode, 1=memory timeout; valid when trap=1
- state  out  4  current state, for debug

Behaviour:
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, TRAP.
- Reset: state=IDLE, wait counter=0, all outputs 0. Reset asserted mid-instruction aborts immediately; no partial write completes after reset.
- IDLE -> FETCH unconditionally. All outputs are 0 in IDLE.
- Unlisted strobes are 0 in every state. Muxes not listed for a state are 0.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00; irwrite=pcwrite=mem_ready.
  - mem_ready=1 -> DECODE.
  - Otherwise stay in FETCH; on timeout -> TRAP(cause 1). PC is not advanced, so the fetch retries.
- DECODE: alusrca=0, alusrcb=11, aluop=00. Next state by opcode:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001000 -> ADDIEX
  - 000010 -> JUMP
  - else -> TRAP(cause 0)
- MEMADR: alusrca=1, alusrcb=10, aluop=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD: memread=1, iord=1. Wait for mem_ready -> MEMWB; timeout -> TRAP(1).
- MEMWB: regdst=0, memtoreg=1, regwrite=1, instr_done=1 -> FETCH.
- MEMWR: memwrite=1, iord=1 held through the wait. mem_ready -> FETCH with instr_done=1; timeout -> TRAP(1).
- EXEC: alusrca=1, alusrcb=00, aluop=10 -> ALUWB.
- ALUWB: regdst=1, memtoreg=0, regwrite=1, instr_done=1 -> FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, pcwritecond=1, pcsrc=01, instr_done=1 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10, aluop=00 -> ADDIWB.
- ADDIWB: regdst=0, memtoreg=0, regwrite=1, instr_done=1 -> FETCH.
- JUMP: pcwrite=1, pcsrc=10, instr_done=1 -> FETCH.
- TRAP: trap=1, trap_cause=latched cause, all strobes 0 -> FETCH. A trapped instruction does not raise instr_done.
- Wait counter:
  - Cleared on entry to FETCH/MEMRD/MEMWR; increments each cycle in those states while mem_ready=0.
  - Timeout fires when mem_ready=0 and counter==MEM_TIMEOUT-1.
  - mem_ready=1 in the same cycle wins over timeout.
  - Saturates at its maximum when MEM_TIMEOUT=0.
- Latency with zero-wait memory, cycles including FETCH: R=4, lw=5, sw=4, beq=3, addi=4, j=3. Each memory wait cycle adds 1.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants: OPC_RTYPE, OPC_LW, OPC_SW, OPC_BEQ, OPC_ADDI, OPC_J
  - aluop, alusrcb and pcsrc encodings
  - 4-bit state enum
- Single module, no sub-modules. Next-state logic and output decode are separate combinational blocks; the state and wait-counter registers form the only sequential block.

Test Plan:
- Reset release, mem_ready tied 1, opcode=000000 -> states IDLE,FETCH,DECODE,EXEC,ALUWB; regwrite=1 and regdst=1 only in ALUWB; instr_done at cycle 4 after FETCH entry.
- lw (100011) with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles with iord=1, memread=1; MEMWB asserts memtoreg=1, regwrite=1; total 8 cycles.
- beq (000100) then j (000010) back-to-back -> BRANCH: pcwritecond=1, pcsrc=01, aluop=01; JUMP: pcwrite=1, pcsrc=10; each instruction takes 3 cycles.
- opcode=111111 -> DECODE, TRAP with trap=1, trap_cause=0, instr_done=0, then FETCH.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> 4 FETCH cycles with irwrite=pcwrite=0, then TRAP with trap_cause=1, then FETCH retries; mem_ready rising on the 4th wait cycle -> DECODE, no trap.
- rst_n pulsed low during MEMWR with mem_ready=0 -> memwrite drops to 0 asynchronously, state=IDLE; FETCH follows one cycle after release.
